// File: rtl/multi_handshake_controller.sv
// Round-robin request/accept/done controller: N_CH requesters share one
// processing slot with a programmable per-transaction processing length.
// Optional feature macro: HS_TIMEOUT_EN adds an accept-phase timeout that
// aborts a transaction whose requester keeps request high for TIMEOUT
// ACCEPTING cycles, signalled by a one-cycle err pulse.
module multi_handshake_controller #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned PROC_W  = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         request_i,
  input  logic [PROC_W-1:0]       proc_len_i,
  output logic [N_CH-1:0]         accept_o,
  output logic [N_CH-1:0]         done_o,
  output logic [$clog2(N_CH)-1:0] grant_id_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned ID_W = $clog2(N_CH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_PROC,
    S_DONE
`ifdef HS_TIMEOUT_EN
    , S_ABORT
`endif
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     grant_q;
  logic [ID_W-1:0]     last_ptr_q;
  logic [PROC_W-1:0]   cnt_q;
  logic [N_CH-1:0]     accept_q;
  logic [N_CH-1:0]     done_q;
  logic                busy_q;

  logic [ID_W-1:0]     idx_c;
  logic [ID_W-1:0]     pick_c;
  logic                found_c;
  logic [N_CH-1:0]     pick_oh_c;
  logic [N_CH-1:0]     grant_oh_c;
  logic [PROC_W-1:0]   len_c;

`ifdef HS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;
  logic          err_q;
`endif

  // Round-robin pick: first set request bit after last_ptr, wrapping modulo N_CH
  always_comb begin
    idx_c   = '0;
    pick_c  = '0;
    found_c = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx_c = ID_W'((32'(last_ptr_q) + i) % N_CH);
      if (!found_c && request_i[idx_c]) begin
        pick_c  = idx_c;
        found_c = 1'b1;
      end
    end
  end

  assign pick_oh_c  = N_CH'(1) << pick_c;
  assign grant_oh_c = N_CH'(1) << grant_q;
  // A zero processing length still occupies one PROCESSING cycle
  assign len_c      = (proc_len_i == '0) ? PROC_W'(1) : proc_len_i;

  // Handshake FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_ptr_q <= ID_W'(N_CH - 1);
      cnt_q      <= '0;
      accept_q   <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
`ifdef HS_TIMEOUT_EN
      tcnt_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_c) begin
            state_q  <= S_ACCEPT;
            grant_q  <= pick_c;
            accept_q <= pick_oh_c;
            busy_q   <= 1'b1;
`ifdef HS_TIMEOUT_EN
            tcnt_q   <= '0;
`endif
          end
        end
        S_ACCEPT: begin
          if (!request_i[grant_q]) begin
            state_q  <= S_PROC;
            cnt_q    <= len_c;
            accept_q <= '0;
          end
`ifdef HS_TIMEOUT_EN
          else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            state_q  <= S_ABORT;
            accept_q <= '0;
            err_q    <= 1'b1;
          end else begin
            tcnt_q   <= tcnt_q + TW'(1);
          end
`endif
        end
        S_PROC: begin
          if (cnt_q == PROC_W'(1)) begin
            state_q <= S_DONE;
            done_q  <= grant_oh_c;
          end else begin
            cnt_q   <= cnt_q - PROC_W'(1);
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          done_q     <= '0;
          busy_q     <= 1'b0;
          last_ptr_q <= grant_q;
        end
`ifdef HS_TIMEOUT_EN
        S_ABORT: begin
          err_q <= 1'b0;
          if (!request_i[grant_q]) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            last_ptr_q <= grant_q;
          end
        end
`endif
        default: begin
          state_q  <= S_IDLE;
          accept_q <= '0;
          done_q   <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign accept_o   = accept_q;
  assign done_o     = done_q;
  assign grant_id_o = grant_q;
  assign busy_o     = busy_q;

`ifdef HS_TIMEOUT_EN
  assign err_o = err_q;
`else
  // Without the timeout feature there is no abort path
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
  assign err_o          = 1'b0;
`endif

endmodule
